// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage feeding the IF/ID pipeline register
//
// Owns the PC and keeps at most one instruction-memory request outstanding.
// Presents instruction, PC and PC+4 to IF/ID. The outputs are held while the
// hazard unit stalls, and a NOP bubble is driven when no live instruction is
// available. Redirects from EX take priority over everything, and any stale
// in-flight response is dropped.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   i_stall             hold current outputs, do not consume
//   i_redirect(_pc)     taken branch/jump and its target
//   o_imem_req/addr     fetch request and address (address = pc)
//   i_imem_ready        memory accepts the request this cycle
//   i_imem_rvalid/rdata response valid and instruction word
//   o_inst/o_PC/o_PC_plus_4/o_valid   IF/ID payload
//
// Optional feature macro IF_MISALIGN_CHECK_EN:
//   adds o_fetch_misalign. A misaligned redirect target raises it and blocks
//   fetching until the next aligned redirect. Without the macro, the low two
//   target bits are forced to zero.

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_PC,
  output logic [31:0] o_PC_plus_4,
  output logic        o_valid
`ifdef IF_MISALIGN_CHECK_EN
  ,output logic       o_fetch_misalign
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_inflight_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic [31:0] pc_p4_q;
  logic        valid_q;

  logic        consume;
  logic        fetch_block;
  logic        accept;
  logic        redirect;
  logic [31:0] redirect_pc_d;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q;
  assign fetch_block      = misalign_q;
  assign redirect_pc_d    = i_redirect_pc;
  assign o_fetch_misalign = misalign_q;
`else
  assign fetch_block   = 1'b0;
  assign redirect_pc_d = i_redirect_pc & ~32'h0000_0003;
`endif

  // The slot is free when it is empty or is being consumed this very cycle.
  // This guarantees that a response never lands on an unconsumed instruction.
  assign consume     = valid_q && !i_stall;
  assign o_imem_req  = (state_q == S_REQ) && (!valid_q || !i_stall) && !fetch_block;
  assign accept      = o_imem_req && i_imem_ready;
  assign redirect    = i_redirect && (state_q != S_IDLE);
  assign o_imem_addr = pc_q;

  assign o_inst      = inst_q;
  assign o_PC        = pc_out_q;
  assign o_PC_plus_4 = pc_p4_q;
  assign o_valid     = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
      inst_q        <= NOP_INST;
      pc_out_q      <= RESET_PC;
      pc_p4_q       <= RESET_PC + 32'd4;
      valid_q       <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      // Consumption empties the slot. A response landing on the same edge
      // overrides this below.
      if (consume) begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end

      if (redirect) begin
        pc_q    <= redirect_pc_d;
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
        misalign_q <= (i_redirect_pc[1:0] != 2'b00);
`endif
      end

      case (state_q)
        S_IDLE: state_q <= S_REQ;

        S_REQ: begin
          if (redirect) begin
            // A request accepted on the redirect edge is for the old path.
            state_q <= accept ? S_DRAIN : S_REQ;
          end else if (accept) begin
            pc_inflight_q <= pc_q;
            pc_q          <= pc_q + 32'd4;
            state_q       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            state_q <= i_imem_rvalid ? S_REQ : S_DRAIN;
          end else if (i_imem_rvalid) begin
            inst_q   <= i_imem_rdata;
            pc_out_q <= pc_inflight_q;
            pc_p4_q  <= pc_inflight_q + 32'd4;
            valid_q  <= 1'b1;
            state_q  <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (i_imem_rvalid) state_q <= S_REQ;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
